note_glyph_decoder: RTL and testbench

//  Inverse of the note glyph generator: accepts a 256-bit 16x16 note glyph streamed as
//  8 x 32-bit beats (MSB beat first: beat0 = map[255:224]) and recovers the 3-bit note

---
 rtl/note_glyph_decoder.sv | 110 +++++++++++
 tb/tb_note_glyph_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/note_glyph_decoder.sv
// Recovers the 3-bit note code from a 16x16 note glyph streamed as 8 x 32-bit beats, MSB beat first.
// Optional STRICT_FRAME_EN: also require border nibbles beat0[31:28]==F and beat7[3:0]==F.
module note_glyph_decoder #(
  parameter int BEAT_W = 32,
  parameter int BAR_W  = 24,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  output logic              note_valid,
  input  logic              note_ready,
  output logic [2:0]        note,
  output logic              note_err,
  output logic [CNT_W-1:0]  glyph_cnt
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t     state;
  logic [2:0] beat_idx;
  logic       bar_found;
  logic [2:0] bar_k;
  logic       frame_ok;
  logic       hit;
  logic       border_ok;
  logic       unused_bits;

  assign hit         = &in_data[BAR_W-1:0];
  assign unused_bits = ^in_data[BEAT_W-1:BAR_W];

`ifdef STRICT_FRAME_EN
  // Top-border check on beat 0 is combined with the bottom-border check on the final beat.
  assign border_ok = (beat_idx == 3'd0) ? (in_data[BEAT_W-1 -: 4] == 4'hF) : frame_ok;
`else
  assign border_ok = 1'b1;
`endif

  // Returns {err, note}; an unrecognised glyph reports note 3'b111.
  function automatic logic [3:0] decode(input logic found, input logic [2:0] k,
                                        input logic frame_good);
    if (found && frame_good && k <= 3'd6) return {1'b0, 3'd6 - k};
    return {1'b1, 3'b111};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      beat_idx   <= 3'd0;
      bar_found  <= 1'b0;
      bar_k      <= 3'd0;
      frame_ok   <= 1'b1;
      in_ready   <= 1'b1;
      note_valid <= 1'b0;
      note       <= 3'd0;
      note_err   <= 1'b0;
      glyph_cnt  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (abort) begin
            beat_idx  <= 3'd0;
            bar_found <= 1'b0;
            frame_ok  <= 1'b1;
          end else if (in_valid) begin
            if (beat_idx == 3'd7) begin
              {note_err, note} <= decode(bar_found, bar_k,
                                         frame_ok && border_ok_last(in_data));
              state      <= HOLD;
              in_ready   <= 1'b0;
              note_valid <= 1'b1;
            end else begin
              beat_idx <= beat_idx + 3'd1;
              if (beat_idx == 3'd0) frame_ok <= border_ok;
              if (hit && !bar_found) begin
                bar_found <= 1'b1;
                bar_k     <= beat_idx;
              end
            end
          end
        end
        HOLD: begin
          if (note_ready) begin
            state      <= COLLECT;
            in_ready   <= 1'b1;
            note_valid <= 1'b0;
            beat_idx   <= 3'd0;
            bar_found  <= 1'b0;
            frame_ok   <= 1'b1;
            glyph_cnt  <= glyph_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Bottom border lives in the low nibble of the final beat.
  function automatic logic border_ok_last(input logic [BEAT_W-1:0] d);
`ifdef STRICT_FRAME_EN
    return d[3:0] == 4'hF;
`else
    return 1'b1 | d[0];
`endif
  endfunction

endmodule

// File: tb/tb_note_glyph_decoder.sv
// Directed bench for note_glyph_decoder: vector table of whole glyphs plus hold/abort/reset sequences.
module tb_note_glyph_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        note_valid;
  logic        note_ready;
  logic [2:0]  note;
  logic        note_err;
  logic [15:0] glyph_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  note_glyph_decoder #(.BEAT_W(32), .BAR_W(24), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .note_valid(note_valid), .note_ready(note_ready), .note(note),
    .note_err(note_err), .glyph_cnt(glyph_cnt)
  );

  typedef struct {
    logic [255:0] g;
    logic [2:0]   note;
    logic         err;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Bar of two rows-of-beats starting at beat k (k<0: no bar); optional border nibbles.
  function automatic logic [255:0] mk(input int k, input bit top, input bit bot);
    logic [255:0] g;
    logic [31:0]  b;
    for (int i = 0; i < 8; i++) begin
      b = 32'h0018_1800;
      if (k >= 0 && (i == k || i == k + 1)) b = 32'h00FF_FFFF;
      if (i == 0 && top) b = b | 32'hF000_0000;
      if (i == 7 && bot) b = b | 32'h0000_000F;
      g[255 - 32*i -: 32] = b;
    end
    return g;
  endfunction

  task automatic send_beat(input logic [31:0] d);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_beats(input logic [255:0] g, input int first, input int last);
    for (int i = first; i <= last; i++) send_beat(g[255 - 32*i -: 32]);
  endtask

  initial begin
    logic [255:0] ga;
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; note_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_note_valid", {31'd0, note_valid}, 32'd0);
    check("rst_note", {29'd0, note}, 32'd0);
    check("rst_err", {31'd0, note_err}, 32'd0);
    check("rst_cnt", {16'd0, glyph_cnt}, 32'd0);
    rst_n = 1'b1;

    // Generator glyphs A..G: bar starts at beat 6-n.
    for (int n = 0; n < 7; n++) tbl[n] = '{mk(6 - n, 1, 1), 3'(n), 1'b0};
    tbl[7]  = '{256'd0, 3'b111, 1'b1};
    tbl[8]  = '{mk(7, 1, 1), 3'b111, 1'b1};
    tbl[9]  = '{mk(-1, 1, 1), 3'b111, 1'b1};
`ifdef STRICT_FRAME_EN
    tbl[10] = '{mk(5, 0, 1), 3'b111, 1'b1};
`else
    tbl[10] = '{mk(5, 0, 1), 3'd1, 1'b0};
`endif

    for (int v = 0; v < 11; v++) begin
      send_beats(tbl[v].g, 0, 7);
      check($sformatf("v%0d_valid_latency", v), {31'd0, note_valid}, 32'd1);
      check($sformatf("v%0d_note", v), {29'd0, note}, {29'd0, tbl[v].note});
      check($sformatf("v%0d_err", v), {31'd0, note_err}, {31'd0, tbl[v].err});
      @(posedge clk); #1;
      exp_cnt++;
      check($sformatf("v%0d_dropped", v), {31'd0, note_valid}, 32'd0);
      check($sformatf("v%0d_cnt", v), {16'd0, glyph_cnt}, exp_cnt);
      if (v == 6) check("cnt_after_seven", {16'd0, glyph_cnt}, 32'd7);
    end

    // Backpressure: result held, beats offered during HOLD are not taken.
    note_ready = 1'b0;
    send_beats(tbl[0].g, 0, 7);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
      check($sformatf("hold%0d_valid", c), {31'd0, note_valid}, 32'd1);
      check($sformatf("hold%0d_note", c), {29'd0, note}, 32'd0);
      check($sformatf("hold%0d_ready", c), {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; note_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt++;
    check("hold_cnt", {16'd0, glyph_cnt}, exp_cnt);
    send_beats(tbl[2].g, 0, 7);
    check("post_hold_note", {29'd0, note}, 32'd2);
    @(posedge clk); #1;
    exp_cnt++;

    // Abort a partial G, then a full C.
    send_beats(tbl[6].g, 0, 3);
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    check("abort_no_valid", {31'd0, note_valid}, 32'd0);
    send_beats(tbl[2].g, 0, 7);
    check("abort_note", {29'd0, note}, 32'd2);
    check("abort_err", {31'd0, note_err}, 32'd0);
    @(posedge clk); #1;
    exp_cnt++;
    check("abort_cnt", {16'd0, glyph_cnt}, exp_cnt);

    // Async reset while beat 4 of D is presented.
    ga = tbl[3].g;
    send_beats(ga, 0, 3);
    @(negedge clk);
    in_valid = 1'b1; in_data = ga[255 - 128 -: 32];
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, note_valid}, 32'd0);
    check("mrst_cnt", {16'd0, glyph_cnt}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_beats(tbl[4].g, 0, 7);
    check("mrst_e_note", {29'd0, note}, 32'd4);
    check("mrst_e_err", {31'd0, note_err}, 32'd0);
    @(posedge clk); #1;
    check("mrst_e_cnt", {16'd0, glyph_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: run exceeded time limit");
    $fatal(1);
  end

endmodule
